sensor_scheduler: RTL and testbench

Request scheduler that shares the DHT11-class sensor front-ends between a single command requester and up to NUM_SENSORS sensor instances. Sits between the command decoder and the per-sensor 40-bit communication modules. It selects the target sensor, pulses its one-hot enable, and bounds each transaction with a timeout. It enforces the mandatory inter-read hold-off per sensor and serves hold-off requests from a per-sensor cache of the last good frame.

---
 rtl/sensor_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_sensor_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_scheduler.sv
// sensor_scheduler: shares DHT11-class sensor front-ends between one command
// requester and NUM_SENSORS sensors. It pulses a one-hot enable for each bus
// read, bounds every read with a timeout, and enforces a per-sensor hold-off.
// Requests that arrive during a hold-off are answered from a per-sensor cache
// of the last good frame.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request; req_ready high
// CHECK | address check, then hold-off/cache decision (may stall here)
// START | enable raised, timeout counter cleared
// WAIT  | enable held; waiting for done/error or timeout
// RESP  | response held on rsp_* until rsp_ready
module sensor_scheduler #(
  parameter int NUM_SENSORS  = 4,
  parameter int MIN_INTERVAL = 100_000_000,
  parameter int TIMEOUT      = 2_500_000
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [7:0]                req_address,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [39:0]               rsp_data,
  output logic [1:0]                rsp_status,
  output logic                      rsp_cached,
  output logic [7:0]                rsp_address,
  output logic [NUM_SENSORS-1:0]    sensor_enable,
  input  logic [40*NUM_SENSORS-1:0] sensor_data,
  input  logic [NUM_SENSORS-1:0]    sensor_done,
  input  logic [NUM_SENSORS-1:0]    sensor_error
);

  localparam int IW = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, CHECK, START, WAIT, RESP} state_t;

  state_t                 state_q;
  logic [7:0]             addr_q;
  logic [TW-1:0]          tmo_q;
  logic [NUM_SENSORS-1:0] enable_q;
  logic [NUM_SENSORS-1:0] cache_valid_q;
  logic [39:0]            cache_q   [NUM_SENSORS];
  logic [26:0]            holdoff_q [NUM_SENSORS];
  logic                   rsp_valid_q;
  logic [39:0]            rsp_data_q;
  logic [1:0]             rsp_status_q;
  logic                   rsp_cached_q;
  logic [7:0]             rsp_address_q;

  logic [39:0]            frame_w [NUM_SENSORS];
  logic [IW-1:0]          idx;
  logic                   addr_bad;
  logic [39:0]            frame_sel;
  logic [7:0]             csum_calc;
  logic                   csum_ok;
  logic                   ev_err;
  logic                   ev_done;
  logic                   ev_tmo;
  logic                   wait_exit;
  logic                   holdoff_zero;

  for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_frame
    assign frame_w[g] = sensor_data[40*g +: 40];
  end

  // The index is only used once the address has been checked against NUM_SENSORS.
  assign idx          = addr_q[IW-1:0];
  assign addr_bad     = (addr_q >= 8'(NUM_SENSORS));
  assign frame_sel    = frame_w[idx];
  assign csum_calc    = frame_sel[39:32] + frame_sel[31:24] + frame_sel[23:16] + frame_sel[15:8];
  assign csum_ok      = (csum_calc == frame_sel[7:0]);
  assign ev_err       = sensor_error[idx];
  assign ev_done      = sensor_done[idx];
  assign ev_tmo       = (tmo_q == TW'(TIMEOUT - 1));
  assign wait_exit    = (state_q == WAIT) && (ev_err || ev_done || ev_tmo);
  assign holdoff_zero = (holdoff_q[idx] == '0);

  assign req_ready     = (state_q == IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_status    = rsp_status_q;
  assign rsp_cached    = rsp_cached_q;
  assign rsp_address   = rsp_address_q;
  assign sensor_enable = enable_q;

  // Per-sensor hold-off: reload when a read on that sensor ends, else count down to 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SENSORS; i++) holdoff_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SENSORS; i++) begin
        if (wait_exit && (idx == IW'(i))) holdoff_q[i] <= 27'(MIN_INTERVAL);
        else if (holdoff_q[i] != '0)      holdoff_q[i] <= holdoff_q[i] - 27'd1;
      end
    end
  end

  // Request FSM with registered enables, response fields and frame cache.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      tmo_q         <= '0;
      enable_q      <= '0;
      cache_valid_q <= '0;
      for (int i = 0; i < NUM_SENSORS; i++) cache_q[i] <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_status_q  <= 2'b00;
      rsp_cached_q  <= 1'b0;
      rsp_address_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_address;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (addr_bad) begin
            rsp_valid_q   <= 1'b1;
            rsp_data_q    <= '0;
            rsp_status_q  <= 2'b11;
            rsp_cached_q  <= 1'b0;
            rsp_address_q <= addr_q;
            state_q       <= RESP;
          end else if (holdoff_zero) begin
            enable_q      <= '0;
            enable_q[idx] <= 1'b1;
            tmo_q         <= '0;
            state_q       <= START;
          end else if (cache_valid_q[idx]) begin
            rsp_valid_q   <= 1'b1;
            rsp_data_q    <= cache_q[idx];
            rsp_status_q  <= 2'b00;
            rsp_cached_q  <= 1'b1;
            rsp_address_q <= addr_q;
            state_q       <= RESP;
          end
        end
        START: begin
          tmo_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (wait_exit) begin
            enable_q      <= '0;
            rsp_valid_q   <= 1'b1;
            rsp_cached_q  <= 1'b0;
            rsp_address_q <= addr_q;
            state_q       <= RESP;
            if (ev_err) begin
              rsp_data_q         <= '0;
              rsp_status_q       <= 2'b01;
              cache_valid_q[idx] <= 1'b0;
            end else if (ev_done) begin
              rsp_data_q <= frame_sel;
              if (csum_ok) begin
                rsp_status_q       <= 2'b00;
                cache_q[idx]       <= frame_sel;
                cache_valid_q[idx] <= 1'b1;
              end else begin
                rsp_status_q       <= 2'b01;
                cache_valid_q[idx] <= 1'b0;
              end
            end else begin
              rsp_data_q         <= '0;
              rsp_status_q       <= 2'b10;
              cache_valid_q[idx] <= 1'b0;
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          enable_q    <= '0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_scheduler.sv
// Directed bench for sensor_scheduler with NUM_SENSORS=4, MIN_INTERVAL=100,
// TIMEOUT=50. Inputs change and outputs are sampled on the falling edge.
module tb_sensor_scheduler;

  localparam int NS = 4;
  localparam logic [39:0] F_OK1 = 40'h230019003C;  // 23+00+19+00 = 3C
  localparam logic [39:0] F_BAD = 40'h230019003D;
  localparam logic [39:0] F_OK2 = 40'h1234050651;  // 12+34+05+06 = 51

  logic            clock = 1'b0;
  logic            reset_n;
  logic            req_valid;
  logic            req_ready;
  logic [7:0]      req_address;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [39:0]     rsp_data;
  logic [1:0]      rsp_status;
  logic            rsp_cached;
  logic [7:0]      rsp_address;
  logic [NS-1:0]   sensor_enable;
  logic [40*NS-1:0] sensor_data;
  logic [NS-1:0]   sensor_done;
  logic [NS-1:0]   sensor_error;

  int vectors     = 0;
  int miscompares = 0;
  int onehot_bad  = 0;

  sensor_scheduler #(.NUM_SENSORS(NS), .MIN_INTERVAL(100), .TIMEOUT(50)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_address(req_address),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_status(rsp_status), .rsp_cached(rsp_cached), .rsp_address(rsp_address),
    .sensor_enable(sensor_enable), .sensor_data(sensor_data),
    .sensor_done(sensor_done), .sensor_error(sensor_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if ($countones(sensor_enable) > 1) onehot_bad++;

  // Present a request for one cycle; returns at the falling edge of the CHECK cycle.
  task automatic send_req(input logic [7:0] a);
    req_valid = 1'b1; req_address = a;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  // Accept the pending response; returns in the following IDLE cycle.
  task automatic accept_rsp();
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
  endtask

  // Called while enable[s] is high; raises done/error in the n-th enable cycle
  // (n = 0: never) and returns the measured enable width.
  task automatic run_pulse(input int s, input int n, input logic d, input logic e,
                           output int width);
    width = 0;
    while (sensor_enable[s] === 1'b1 && width < 200) begin
      width++;
      if (n != 0 && width == n) begin
        sensor_done[s] = d; sensor_error[s] = e;
      end
      @(negedge clock);
      sensor_done = '0; sensor_error = '0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; req_address = '0; rsp_ready = 1'b0;
    sensor_data = '0; sensor_done = '0; sensor_error = '0;
    repeat (2) @(negedge clock);
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got %b expected 1", req_ready); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b expected 0", rsp_valid); end
    vectors++; if (rsp_data !== 40'h0) begin miscompares++; $display("FAIL reset_rsp_data got %h expected 0", rsp_data); end
    vectors++; if ({rsp_status, rsp_cached} !== 3'b000) begin miscompares++; $display("FAIL reset_status_cached got %b expected 000", {rsp_status, rsp_cached}); end
    vectors++; if (rsp_address !== 8'h00) begin miscompares++; $display("FAIL reset_rsp_address got %h expected 00", rsp_address); end
    vectors++; if (sensor_enable !== 4'b0000) begin miscompares++; $display("FAIL reset_enable got %b expected 0000", sensor_enable); end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_fresh_read();
    int w;
    sensor_data[40*1 +: 40] = F_OK1;
    send_req(8'h01);
    vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL fresh_req_ready_drop got %b expected 0", req_ready); end
    vectors++; if (sensor_enable !== 4'b0000) begin miscompares++; $display("FAIL fresh_enable_check got %b expected 0000", sensor_enable); end
    @(negedge clock);
    vectors++; if (sensor_enable !== 4'b0010) begin miscompares++; $display("FAIL fresh_enable_start got %b expected 0010", sensor_enable); end
    run_pulse(1, 11, 1'b1, 1'b0, w);
    vectors++; if (w !== 11) begin miscompares++; $display("FAIL fresh_enable_width got %0d expected 11", w); end
    vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL fresh_rsp_valid got %b expected 1", rsp_valid); end
    vectors++; if (rsp_data !== F_OK1) begin miscompares++; $display("FAIL fresh_rsp_data got %h expected %h", rsp_data, F_OK1); end
    vectors++; if ({rsp_status, rsp_cached} !== 3'b000) begin miscompares++; $display("FAIL fresh_status_cached got %b expected 000", {rsp_status, rsp_cached}); end
    vectors++; if (rsp_address !== 8'h01) begin miscompares++; $display("FAIL fresh_rsp_address got %h expected 01", rsp_address); end
    accept_rsp();
    vectors++; if ({req_ready, rsp_valid} !== 2'b10) begin miscompares++; $display("FAIL fresh_after_accept got %b expected 10", {req_ready, rsp_valid}); end
  endtask

  task automatic test_cached_read();
    int w;
    send_req(8'h01);
    @(negedge clock);
    vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL cached_rsp_valid got %b expected 1", rsp_valid); end
    vectors++; if (rsp_data !== F_OK1) begin miscompares++; $display("FAIL cached_rsp_data got %h expected %h", rsp_data, F_OK1); end
    vectors++; if ({rsp_status, rsp_cached} !== 3'b001) begin miscompares++; $display("FAIL cached_status_cached got %b expected 001", {rsp_status, rsp_cached}); end
    vectors++; if (sensor_enable !== 4'b0000) begin miscompares++; $display("FAIL cached_no_enable got %b expected 0000", sensor_enable); end
    accept_rsp();
    repeat (110) @(negedge clock);
    sensor_data[40*1 +: 40] = F_OK2;
    send_req(8'h01);
    @(negedge clock);
    vectors++; if (sensor_enable !== 4'b0010) begin miscompares++; $display("FAIL expired_enable got %b expected 0010", sensor_enable); end
    run_pulse(1, 3, 1'b1, 1'b0, w);
    vectors++; if ({rsp_data, rsp_status, rsp_cached} !== {F_OK2, 3'b000}) begin miscompares++; $display("FAIL expired_rsp got %h/%b expected %h/000", rsp_data, {rsp_status, rsp_cached}, F_OK2); end
    accept_rsp();
  endtask

  task automatic test_bad_checksum();
    int w, cnt, early;
    sensor_data[40*2 +: 40] = F_BAD;
    send_req(8'h02);
    @(negedge clock);
    vectors++; if (sensor_enable !== 4'b0100) begin miscompares++; $display("FAIL badsum_enable got %b expected 0100", sensor_enable); end
    run_pulse(2, 4, 1'b1, 1'b0, w);
    vectors++; if ({rsp_status, rsp_cached} !== 3'b010) begin miscompares++; $display("FAIL badsum_status got %b expected 010", {rsp_status, rsp_cached}); end
    vectors++; if (rsp_data !== F_BAD) begin miscompares++; $display("FAIL badsum_data got %h expected %h", rsp_data, F_BAD); end
    accept_rsp();
    send_req(8'h02);
    cnt = 0; early = 0;
    while (sensor_enable === 4'b0000 && cnt < 300) begin
      if (rsp_valid !== 1'b0) early++;
      @(negedge clock);
      cnt++;
    end
    vectors++; if (cnt !== 99) begin miscompares++; $display("FAIL holdoff_stall_cycles got %0d expected 99", cnt); end
    vectors++; if (early !== 0) begin miscompares++; $display("FAIL holdoff_stall_rsp got %0d expected 0", early); end
    vectors++; if (sensor_enable !== 4'b0100) begin miscompares++; $display("FAIL holdoff_fresh_enable got %b expected 0100", sensor_enable); end
    sensor_data[40*2 +: 40] = F_OK2;
    run_pulse(2, 2, 1'b1, 1'b0, w);
    vectors++; if ({rsp_data, rsp_status} !== {F_OK2, 2'b00}) begin miscompares++; $display("FAIL holdoff_read got %h/%b expected %h/00", rsp_data, rsp_status, F_OK2); end
    accept_rsp();
  endtask

  task automatic test_timeout_bad_addr();
    int w;
    send_req(8'h03);
    @(negedge clock);
    vectors++; if (sensor_enable !== 4'b1000) begin miscompares++; $display("FAIL timeout_enable got %b expected 1000", sensor_enable); end
    run_pulse(3, 0, 1'b0, 1'b0, w);
    vectors++; if (w !== 51) begin miscompares++; $display("FAIL timeout_width got %0d expected 51", w); end
    vectors++; if ({rsp_valid, rsp_status} !== 3'b110) begin miscompares++; $display("FAIL timeout_rsp got %b expected 110", {rsp_valid, rsp_status}); end
    accept_rsp();
    send_req(8'h07);
    vectors++; if (sensor_enable !== 4'b0000) begin miscompares++; $display("FAIL badaddr_enable_t1 got %b expected 0000", sensor_enable); end
    @(negedge clock);
    vectors++; if ({rsp_valid, rsp_status, rsp_cached} !== 4'b1110) begin miscompares++; $display("FAIL badaddr_rsp got %b expected 1110", {rsp_valid, rsp_status, rsp_cached}); end
    vectors++; if ({rsp_data, rsp_address} !== {40'h0, 8'h07}) begin miscompares++; $display("FAIL badaddr_data_addr got %h/%h expected 0/07", rsp_data, rsp_address); end
    vectors++; if (sensor_enable !== 4'b0000) begin miscompares++; $display("FAIL badaddr_enable_t2 got %b expected 0000", sensor_enable); end
    accept_rsp();
  endtask

  task automatic test_simultaneous_stall();
    int w, bad;
    logic [39:0] snap;
    sensor_data[40*0 +: 40] = F_OK2;
    send_req(8'h00);
    @(negedge clock);
    vectors++; if (sensor_enable !== 4'b0001) begin miscompares++; $display("FAIL simul_enable got %b expected 0001", sensor_enable); end
    run_pulse(0, 5, 1'b1, 1'b1, w);
    vectors++; if ({rsp_valid, rsp_status, rsp_cached} !== 4'b1010) begin miscompares++; $display("FAIL simul_err_priority got %b expected 1010", {rsp_valid, rsp_status, rsp_cached}); end
    snap = rsp_data;
    bad = 0;
    req_valid = 1'b1; req_address = 8'h02;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (rsp_valid !== 1'b1 || rsp_status !== 2'b01 || rsp_cached !== 1'b0 ||
          rsp_address !== 8'h00 || rsp_data !== snap || req_ready !== 1'b0 ||
          sensor_enable !== 4'b0000) bad++;
    end
    req_valid = 1'b0;
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL stall_stability got %0d unstable cycles expected 0", bad); end
    accept_rsp();
    vectors++; if ({req_ready, rsp_valid} !== 2'b10) begin miscompares++; $display("FAIL stall_release got %b expected 10", {req_ready, rsp_valid}); end
  endtask

  task automatic test_reset_mid_wait();
    int w;
    repeat (120) @(negedge clock);
    sensor_data[40*2 +: 40] = F_OK1;
    sensor_data[40*3 +: 40] = F_OK2;
    send_req(8'h02);
    @(negedge clock);
    run_pulse(2, 2, 1'b1, 1'b0, w);
    vectors++; if ({rsp_data, rsp_status} !== {F_OK1, 2'b00}) begin miscompares++; $display("FAIL prereset_read got %h/%b expected %h/00", rsp_data, rsp_status, F_OK1); end
    accept_rsp();
    send_req(8'h03);
    @(negedge clock);
    repeat (3) @(negedge clock);
    vectors++; if (sensor_enable !== 4'b1000) begin miscompares++; $display("FAIL midwait_enable got %b expected 1000", sensor_enable); end
    #2 reset_n = 1'b0;
    #1;
    vectors++; if ({sensor_enable, rsp_valid} !== 5'b00000) begin miscompares++; $display("FAIL async_reset_drop got %b expected 00000", {sensor_enable, rsp_valid}); end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    send_req(8'h03);
    @(negedge clock);
    vectors++; if (sensor_enable !== 4'b1000) begin miscompares++; $display("FAIL postreset_start got %b expected 1000", sensor_enable); end
    run_pulse(3, 2, 1'b1, 1'b0, w);
    vectors++; if ({rsp_data, rsp_status} !== {F_OK2, 2'b00}) begin miscompares++; $display("FAIL postreset_read got %h/%b expected %h/00", rsp_data, rsp_status, F_OK2); end
    accept_rsp();
    send_req(8'h02);
    @(negedge clock);
    vectors++; if ({sensor_enable, rsp_valid} !== 5'b01000) begin miscompares++; $display("FAIL postreset_cache_cleared got %b expected 01000", {sensor_enable, rsp_valid}); end
    run_pulse(2, 2, 1'b1, 1'b0, w);
    accept_rsp();
  endtask

  initial begin
    test_reset();
    test_fresh_read();
    test_cached_read();
    test_bad_checksum();
    test_timeout_bad_addr();
    test_simultaneous_stall();
    test_reset_mid_wait();
    vectors++; if (onehot_bad !== 0) begin miscompares++; $display("FAIL enable_onehot got %0d multi-hot cycles expected 0", onehot_bad); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
